// File: rtl/vx_launch_bus_master_if.sv
// vx_launch_bus_master_if: launch command, generic-bus and completion signals of the Vortex launch master
interface vx_launch_bus_master_if;
  logic        launch_valid;
  logic        launch_ready;
  logic [31:0] launch_pc;
  logic [31:0] launch_arg;
  logic [31:0] gb_addr;
  logic        gb_ren;
  logic        gb_wen;
  logic [31:0] gb_wdata;
  logic [3:0]  gb_byte_en;
  logic [31:0] gb_rdata;
  logic        gb_busy;
  logic        done_valid;
  logic        done_timeout;
  logic [31:0] done_cycles;
  modport master (
    input  launch_valid, launch_pc, launch_arg, gb_rdata, gb_busy,
    output launch_ready, gb_addr, gb_ren, gb_wen, gb_wdata, gb_byte_en,
           done_valid, done_timeout, done_cycles
  );
  modport slave (
    output launch_valid, launch_pc, launch_arg, gb_rdata, gb_busy,
    input  launch_ready, gb_addr, gb_ren, gb_wen, gb_wdata, gb_byte_en,
           done_valid, done_timeout, done_cycles
  );
endinterface

// File: rtl/vx_launch_bus_master.sv
// vx_launch_bus_master: writes PC/arg/start to the Vortex control slave, polls status until idle; VX_LAUNCH_PERF_EN adds a done_cycles counter
module vx_launch_bus_master #(
  parameter logic [31:0] CTRL_BASE      = 32'h0000_F000,
  parameter int unsigned POLL_GAP       = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input logic clk,
  input logic reset,
  vx_launch_bus_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_PC, WR_ARG, WR_START, POLL_RD, POLL_GAP_WAIT, DONE} state_t;
  state_t      state, state_nx;
  logic [31:0] pc_r, arg_r, tmo, gap;
  logic        to_r, to_nx, hit, polling, start_done, unused_rdata;
  assign hit          = (TIMEOUT_CYCLES != 32'd0) && (tmo >= TIMEOUT_CYCLES);
  assign polling      = (state == POLL_RD) || (state == POLL_GAP_WAIT);
  assign start_done   = (state == WR_START) && !bus.gb_busy;
  assign unused_rdata = ^bus.gb_rdata[31:1];
  always_comb begin
    state_nx = state;
    to_nx    = to_r;
    case (state)
      IDLE:     state_nx = bus.launch_valid ? WR_PC : IDLE;
      WR_PC:    state_nx = bus.gb_busy ? WR_PC : WR_ARG;
      WR_ARG:   state_nx = bus.gb_busy ? WR_ARG : WR_START;
      WR_START: state_nx = bus.gb_busy ? WR_START : POLL_RD;
      POLL_RD:
        if (!bus.gb_busy) begin
          if (!bus.gb_rdata[0]) begin
            state_nx = DONE;
            to_nx    = 1'b0;
          end else if (hit) begin
            state_nx = DONE;
            to_nx    = 1'b1;
          end else begin
            state_nx = (POLL_GAP == 0) ? POLL_RD : POLL_GAP_WAIT;
          end
        end
      POLL_GAP_WAIT:
        if (hit) begin
          state_nx = DONE;
          to_nx    = 1'b1;
        end else begin
          state_nx = (gap == 32'd0) ? POLL_RD : POLL_GAP_WAIT;
        end
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc_r  <= '0;
      arg_r <= '0;
      tmo   <= '0;
      gap   <= '0;
      to_r  <= 1'b0;
    end else begin
      state <= state_nx;
      to_r  <= to_nx;
      if (state == IDLE && bus.launch_valid) begin
        pc_r  <= bus.launch_pc;
        arg_r <= bus.launch_arg;
      end
      if (start_done) tmo <= '0;
      else if (polling && !hit) tmo <= tmo + 32'd1;
      if (state == POLL_RD && state_nx == POLL_GAP_WAIT) gap <= POLL_GAP - 1;
      else if (state == POLL_GAP_WAIT && gap != 32'd0) gap <= gap - 32'd1;
    end
  end
  assign bus.launch_ready = (state == IDLE);
  assign bus.gb_wen       = (state == WR_PC) || (state == WR_ARG) || (state == WR_START);
  assign bus.gb_ren       = (state == POLL_RD);
  assign bus.gb_byte_en   = (bus.gb_wen || bus.gb_ren) ? 4'hF : 4'h0;
  assign bus.gb_addr      = (state == WR_PC)    ? CTRL_BASE :
                            (state == WR_ARG)   ? CTRL_BASE + 32'h4 :
                            (state == WR_START) ? CTRL_BASE + 32'h8 :
                            (state == POLL_RD)  ? CTRL_BASE + 32'hC : 32'h0;
  assign bus.gb_wdata     = (state == WR_PC)    ? pc_r :
                            (state == WR_ARG)   ? arg_r :
                            (state == WR_START) ? 32'h1 : 32'h0;
  assign bus.done_valid   = (state == DONE);
  assign bus.done_timeout = (state == DONE) && to_r;
`ifdef VX_LAUNCH_PERF_EN
  logic [31:0] cyc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc <= '0;
    else if (start_done) cyc <= '0;
    else if (polling && cyc != 32'hFFFF_FFFF) cyc <= cyc + 32'd1;
  end
  assign bus.done_cycles = (state != DONE) ? 32'h0 :
                           (cyc == 32'hFFFF_FFFF) ? cyc : cyc + 32'd1;
`else
  assign bus.done_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_vx_launch_bus_master.sv
// tb_vx_launch_bus_master: scoreboard bench with a stalling control-slave model and directed launches
module tb_vx_launch_bus_master;
  typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} xfer_t;
  typedef struct {int cyc; logic to; logic [31:0] cycles;} done_t;
`ifdef VX_LAUNCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  vx_launch_bus_master_if bus();
  vx_launch_bus_master #(.TIMEOUT_CYCLES(32'd40)) dut (.clk(clk), .reset(reset), .bus(bus));
  xfer_t xq[$];
  done_t dq[$];
  xfer_t x;
  done_t d;
  int errors = 0, checks = 0, cycnum = 0;
  int stall = 0, busy_reads = 0, rd_stall_idx = -1, rd_stall_len = 0, rd_base = 0;
  int reads_done = 0, wait_cnt = 0, cur_stall;
  logic p_busy = 1'b0;
  logic [65:0] p_bus = '0;
  assign cur_stall   = (bus.gb_ren && (reads_done - rd_base) == rd_stall_idx) ? rd_stall_len : stall;
  assign bus.gb_busy = (bus.gb_ren || bus.gb_wen) && (wait_cnt < cur_stall);
  assign bus.gb_rdata = {31'b0, ((reads_done - rd_base) < busy_reads)};
  always @(posedge clk) begin
    cycnum   <= cycnum + 1;
    wait_cnt <= ((bus.gb_ren || bus.gb_wen) && bus.gb_busy) ? wait_cnt + 1 : 0;
    if (bus.gb_ren && !bus.gb_busy) reads_done <= reads_done + 1;
  end
  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      if (p_busy) chk("stall_hold", {bus.gb_ren, bus.gb_wen, bus.gb_addr, bus.gb_wdata}, p_bus);
      if (bus.gb_ren || bus.gb_wen) chk("req_excl_be", {bus.gb_ren & bus.gb_wen, bus.gb_byte_en}, {1'b0, 4'hF});
      if ((bus.gb_ren || bus.gb_wen) && !bus.gb_busy) begin
        if (xq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got wen=%0b addr=%h, expected no transfer", bus.gb_wen, bus.gb_addr);
        end else begin
          x = xq.pop_front();
          chk("xfer", {bus.gb_wen, bus.gb_addr, bus.gb_wen ? bus.gb_wdata : 32'h0}, {x.wr, x.addr, x.data});
        end
      end
      if (bus.done_valid) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_valid=1 at cycle %0d, expected none", cycnum);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", 66'(cycnum), 66'(d.cyc));
          chk("done_timeout", {65'b0, bus.done_timeout}, {65'b0, d.to});
          chk("done_cycles", {34'b0, bus.done_cycles}, {34'b0, d.cycles});
        end
      end
      p_busy = (bus.gb_ren || bus.gb_wen) && bus.gb_busy;
      p_bus  = {bus.gb_ren, bus.gb_wen, bus.gb_addr, bus.gb_wdata};
    end else begin
      p_busy = 1'b0;
    end
  end
  task automatic expect_launch(input logic [31:0] pc, input logic [31:0] arg, input int nreads,
                               input int acc, input int lat, input logic to, input logic [31:0] cyc);
    xq.push_back(xfer_t'{1'b1, 32'hF000, pc});
    xq.push_back(xfer_t'{1'b1, 32'hF004, arg});
    xq.push_back(xfer_t'{1'b1, 32'hF008, 32'h1});
    for (int i = 0; i < nreads; i++) xq.push_back(xfer_t'{1'b0, 32'hF00C, 32'h0});
    dq.push_back(done_t'{acc + lat, to, PERF ? cyc : 32'h0});
  endtask
  task automatic wait_ready(output int acc);
    int i = 0;
    acc = -1;
    do begin
      @(negedge clk);
      i++;
    end while (!bus.launch_ready && i < 200);
    if (bus.launch_ready) acc = cycnum;
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got launch_ready=0 for 200 cycles, expected 1");
    end
  endtask
  task automatic launch(input logic [31:0] pc, input logic [31:0] arg, output int acc);
    @(posedge clk);
    #1;
    bus.launch_pc    = pc;
    bus.launch_arg   = arg;
    bus.launch_valid = 1'b1;
    wait_ready(acc);
    @(posedge clk);
    #1;
    bus.launch_valid = 1'b0;
  endtask
  task automatic drain();
    int i = 0;
    while ((xq.size() != 0 || dq.size() != 0) && i < 500) begin
      @(negedge clk);
      i++;
    end
    if (xq.size() != 0 || dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d xfers %0d dones outstanding, expected 0", xq.size(), dq.size());
      xq.delete();
      dq.delete();
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic slave_cfg(input int st, input int br, input int si, input int sl);
    stall        = st;
    busy_reads   = br;
    rd_stall_idx = si;
    rd_stall_len = sl;
    rd_base      = reads_done;
  endtask
  initial begin
    int acc, acc2;
    bus.launch_valid = 1'b0;
    bus.launch_pc    = '0;
    bus.launch_arg   = '0;
    #1;
    chk("rst_ready", {65'b0, bus.launch_ready}, 66'd1);
    chk("rst_req", {bus.gb_ren, bus.gb_wen, bus.gb_addr, bus.gb_wdata}, 66'd0);
    chk("rst_be", {62'b0, bus.gb_byte_en}, 66'd0);
    chk("rst_done", {bus.done_valid, bus.done_timeout, bus.done_cycles}, 34'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    slave_cfg(0, 0, -1, 0);
    launch(32'h8000_0000, 32'h0000_1000, acc);
    expect_launch(32'h8000_0000, 32'h0000_1000, 1, acc, 5, 1'b0, 32'd2);
    drain();
    slave_cfg(3, 0, -1, 0);
    launch(32'h1234_5678, 32'h0000_ABCD, acc);
    expect_launch(32'h1234_5678, 32'h0000_ABCD, 1, acc, 17, 1'b0, 32'd5);
    drain();
    slave_cfg(0, 4, -1, 0);
    launch(32'h0000_0100, 32'h0000_2000, acc);
    expect_launch(32'h0000_0100, 32'h0000_2000, 5, acc, 41, 1'b0, 32'd38);
    drain();
    slave_cfg(0, 1000, -1, 0);
    launch(32'h0000_0200, 32'h0000_3000, acc);
    expect_launch(32'h0000_0200, 32'h0000_3000, 5, acc, 45, 1'b1, 32'd42);
    drain();
    chk("ready_after_timeout", {65'b0, bus.launch_ready}, 66'd1);
    slave_cfg(0, 1000, 4, 5);
    launch(32'h0000_0300, 32'h0000_4000, acc);
    expect_launch(32'h0000_0300, 32'h0000_4000, 5, acc, 46, 1'b1, 32'd43);
    drain();
    slave_cfg(0, 4, 4, 5);
    launch(32'h0000_0400, 32'h0000_5000, acc);
    expect_launch(32'h0000_0400, 32'h0000_5000, 5, acc, 46, 1'b0, 32'd43);
    drain();
    slave_cfg(3, 0, -1, 0);
    launch(32'hDEAD_0000, 32'h0000_6000, acc);
    expect_launch(32'hDEAD_0000, 32'h0000_6000, 1, acc, 17, 1'b0, 32'd5);
    repeat (6) @(negedge clk);
    chk("pre_rst_wr_arg", {bus.gb_wen, bus.gb_addr}, {1'b1, 32'hF004});
    #2 reset = 1'b0;
    #1;
    chk("midrst_req", {bus.gb_ren, bus.gb_wen, bus.done_valid}, 66'd0);
    xq.delete();
    dq.delete();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("post_rst_ready", {bus.launch_ready, bus.gb_ren, bus.gb_wen}, 66'b100);
    slave_cfg(0, 0, -1, 0);
    launch(32'hCAFE_0000, 32'h0000_7000, acc);
    expect_launch(32'hCAFE_0000, 32'h0000_7000, 1, acc, 5, 1'b0, 32'd2);
    drain();
    @(posedge clk);
    #1;
    bus.launch_pc    = 32'hAAAA_0000;
    bus.launch_arg   = 32'h0000_8000;
    bus.launch_valid = 1'b1;
    wait_ready(acc);
    expect_launch(32'hAAAA_0000, 32'h0000_8000, 1, acc, 5, 1'b0, 32'd2);
    @(posedge clk);
    #1;
    bus.launch_pc  = 32'hBBBB_0000;
    bus.launch_arg = 32'h0000_9000;
    wait_ready(acc2);
    chk("hold_accept_cycle", 66'(acc2), 66'(acc + 6));
    expect_launch(32'hBBBB_0000, 32'h0000_9000, 1, acc2, 5, 1'b0, 32'd2);
    @(posedge clk);
    #1;
    bus.launch_valid = 1'b0;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1000000, expected finish");
    $fatal(1);
  end
endmodule
